inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 64'h0000000080000000, PC value loaded on reset.
REQ-002 Parameter: XLEN, 64, width of PC and address buses.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 mem_req_valid  out  1  fetch request to instruction memory.
REQ-006 mem_req_ready  in  1  memory accepts request this cycle.
REQ-007 mem_req_addr  out  XLEN  fetch address, equal to current PC.
REQ-008 mem_resp_valid  in  1  fetch data returned this cycle.
REQ-009 mem_resp_data  in  32  returned instruction word.
REQ-010 out_valid  out  1  instruction available to decode.
REQ-011 out_ready  in  1  decode consumes instruction this cycle.
REQ-012 out_pc  out  XLEN  PC of presented instruction.
REQ-013 out_inst  out  32  presented instruction word.
REQ-014 out_fault  out  1  presented PC misaligned (pc[1:0] != 0).
REQ-015 redirect_valid  in  1  execute stage requests PC change.
REQ-016 redirect_pc  in  XLEN  redirect target.

Function
REQ-017 FSM states SHALL be REQ, WAIT, HOLD, DROP; at most one memory request outstanding.
REQ-018 REQ: mem_req_valid=1 and mem_req_addr=pc when pc[1:0]==0; on mem_req_ready, go to WAIT.
REQ-019 REQ with pc[1:0]!=0: mem_req_valid=0; next cycle HOLD with out_fault=1, out_inst=0.
REQ-020 WAIT: on mem_resp_valid, latch mem_resp_data into out_inst, go to HOLD; mem_resp_valid outside WAIT/DROP SHALL be ignored.
REQ-021 HOLD: out_valid=1; out_pc, out_inst, out_fault stable until handshake; on out_ready, pc<=pc+4 (modulo 2^XLEN), out_valid=0 next cycle, go to REQ.
REQ-022 Redirect in REQ without handshake: pc<=redirect_pc, stay REQ; mem_req_addr may change while mem_req_valid is high only in this case.
REQ-023 Redirect in REQ with mem_req_ready in same cycle, or redirect in WAIT without mem_resp_valid: pc<=redirect_pc, go to DROP.
REQ-024 Redirect in WAIT with mem_resp_valid same cycle: discard data, pc<=redirect_pc, go to REQ.
REQ-025 DROP: discard next mem_resp_valid, then REQ; further redirect in DROP updates pc only.
REQ-026 Redirect in HOLD takes priority over out_ready: pc<=redirect_pc, out_valid=0 next cycle, go to REQ, no pc+4.
REQ-027 Latency: REQ->HOLD minimum 2 cycles with zero-wait memory; min 3 cycles per instruction.
REQ-028 out_valid SHALL be 0 in every state except HOLD.

Reset
REQ-029 On rst: pc=RESET_PC, state=REQ, out_valid=0, out_inst=0, out_pc=0, out_fault=0; rst overrides redirect and all handshakes.
REQ-030 Reset mid-operation abandons any outstanding fetch; memory shares rst, so no stale response is returned.
REQ-031 mem_req_valid SHALL be 0 during the rst cycle and may assert the cycle after.

Structure
REQ-032 Shared package lemon_pkg SHALL hold the FSM state enum, RESET_PC default and XLEN.
REQ-033 No sub-module required; pc+4 adder and FSM inline.

Verification
REQ-034 Reset, mem ready=1, 1-cycle response 32'h00000413 -> req addr 0x80000000, out_valid with out_pc 0x80000000, out_inst 0x00000413.
REQ-035 Stream 3 words, out_ready=1 -> out_pc 0x80000000, 0x80000004, 0x80000008 in order, none dropped or duplicated.
REQ-036 out_ready=0 for 5 cycles in HOLD -> out_valid, out_pc, out_inst unchanged; no new mem request issued.
REQ-037 Redirect to 0x80000100 in WAIT, response 0xDEADBEEF arrives later -> 0xDEADBEEF never presented; next req addr 0x80000100.
REQ-038 Redirect to 0x80000202 -> no mem request; out_valid=1, out_fault=1, out_pc 0x80000202, out_inst 0.
REQ-039 rst asserted in WAIT -> next cycle out_valid=0; following req addr 0x80000000.

Source files
------------

// File: rtl/lemon_pkg.sv
// ---------------------------------------------------------------------------
// lemon_pkg
//   Shared definitions for the lemon front end.
//   - XLEN      : width of PC and instruction-memory address buses
//   - RESET_PC  : default PC loaded on reset
//   - fetch_state_e : instruction-fetch FSM state encoding
// ---------------------------------------------------------------------------
package lemon_pkg;

  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // presenting a fetch request for pc
    ST_WAIT = 2'd1,  // request accepted, waiting for the instruction word
    ST_HOLD = 2'd2,  // instruction presented to decode
    ST_DROP = 2'd3   // request accepted but stale; swallow its response
  } fetch_state_e;

endpackage : lemon_pkg

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Single-outstanding instruction fetch unit. Issues one memory request for
//   the current pc, waits for the returned word, presents it to decode and
//   advances pc by 4 once decode consumes it. Execute-stage redirects replace
//   pc at any point; an in-flight response belonging to the old pc is
//   discarded. A misaligned pc never reaches memory and is presented to decode
//   as a faulting instruction with a zero word.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   mem_req_valid/ready : request handshake to instruction memory
//   mem_req_addr        : fetch address (always equals pc)
//   mem_resp_valid/data : instruction word returned by memory
//   out_valid/ready     : handshake to decode
//   out_pc/inst/fault   : presented instruction, its pc, misalignment flag
//   redirect_valid/pc   : pc change request from execute
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter int              XLEN     = lemon_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(lemon_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,

  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [31:0]     mem_resp_data,

  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_fault,

  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  import lemon_pkg::*;

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic            pc_aligned;
  logic [XLEN-1:0] pc_plus4;

  assign pc_aligned = (pc[1:0] == 2'b00);
  // Wraps modulo 2^XLEN by construction of the fixed-width add.
  assign pc_plus4   = pc + XLEN'(4);

  // Requests only leave from REQ with an aligned pc. The rst term keeps the
  // request low during the reset cycle itself, whatever state we were in.
  assign mem_req_valid = !rst && (state == ST_REQ) && pc_aligned;
  assign mem_req_addr  = pc;
  assign out_valid     = (state == ST_HOLD);

  // NOTE: all state below is updated with non-blocking assignments so every
  // branch sees the pre-edge values of state and pc.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_REQ;
      pc        <= RESET_PC;
      out_pc    <= '0;
      out_inst  <= '0;
      out_fault <= 1'b0;
    end else begin
      unique case (state)
        ST_REQ: begin
          if (!pc_aligned) begin
            // Misaligned pc: no memory access, present a fault instead.
            if (redirect_valid) begin
              pc <= redirect_pc;
            end else begin
              out_pc    <= pc;
              out_inst  <= '0;
              out_fault <= 1'b1;
              state     <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            pc <= redirect_pc;
            // If memory took the old address this cycle, its response is stale.
            state <= mem_req_ready ? ST_DROP : ST_REQ;
          end else if (mem_req_ready) begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            // A response arriving with the redirect is dropped on the floor;
            // otherwise it is still owed and must be swallowed in DROP.
            state <= mem_resp_valid ? ST_REQ : ST_DROP;
          end else if (mem_resp_valid) begin
            out_pc    <= pc;
            out_inst  <= mem_resp_data;
            out_fault <= 1'b0;
            state     <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          // Redirect wins over the decode handshake: no pc+4.
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= ST_REQ;
          end else if (out_ready) begin
            pc    <= pc_plus4;
            state <= ST_REQ;
          end
        end

        ST_DROP: begin
          if (redirect_valid) pc <= redirect_pc;
          if (mem_resp_valid) state <= ST_REQ;
        end

        default: state <= ST_REQ;
      endcase
    end
  end

endmodule : inst_fetch

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//   Directed bench for inst_fetch. Memory and decode are driven by hand from a
//   single initial block; outputs are sampled 1 time unit after each rising
//   edge and compared against hand-computed values.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid;
  logic [31:0]     mem_resp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  logic            out_fault;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_fault      (out_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch one word from REQ with a zero-wait memory; ends in HOLD.
  task automatic fetch(input logic [63:0] addr, input logic [31:0] data);
    chk("req_valid", 64'(mem_req_valid), 64'd1);
    chk("req_addr", mem_req_addr, addr);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("wait_no_req", 64'(mem_req_valid), 64'd0);
    chk("wait_no_out", 64'(out_valid), 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    step();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    chk("hold_valid", 64'(out_valid), 64'd1);
    chk("hold_pc", out_pc, addr);
    chk("hold_inst", 64'(out_inst), 64'(data));
    chk("hold_fault", 64'(out_fault), 64'd0);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("consumed_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst            = 1'b1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    out_ready      = 1'b0;
    redirect_valid = 1'b1;           // must be overridden by reset
    redirect_pc    = 64'h1234;
    step();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step();

    // Reset state (rst still high)
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_fault", 64'(out_fault), 64'd0);
    rst = 1'b0;
    #1;

    // Stream of three words
    fetch(64'h8000_0000, 32'h0000_0413);
    consume();
    fetch(64'h8000_0004, 32'h0010_0093);
    consume();
    fetch(64'h8000_0008, 32'h0020_0113);
    consume();

    // Stall in HOLD for 5 cycles; stray memory activity must be ignored
    fetch(64'h8000_000C, 32'h0030_0193);
    for (int i = 0; i < 5; i++) begin
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hBAD0_BAD0;
      step();
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_pc", out_pc, 64'h8000_000C);
      chk("stall_inst", 64'(out_inst), 64'h0030_0193);
      chk("stall_no_req", 64'(mem_req_valid), 64'd0);
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    consume();

    // Redirect in WAIT, stale response arrives later
    chk("redir_wait_addr", mem_req_addr, 64'h8000_0010);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    step();
    redirect_valid = 1'b0;
    chk("drop_no_req", 64'(mem_req_valid), 64'd0);
    chk("drop_no_out", 64'(out_valid), 64'd0);
    step();
    chk("drop_idle_no_req", 64'(mem_req_valid), 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEAD_BEEF;
    step();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    chk("drop_stale_not_out", 64'(out_valid), 64'd0);
    fetch(64'h8000_0100, 32'h0040_0213);
    consume();

    // Redirect in HOLD beats out_ready
    fetch(64'h8000_0104, 32'h0050_0293);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    out_ready      = 1'b1;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    chk("hold_redir_valid", 64'(out_valid), 64'd0);
    chk("hold_redir_addr", mem_req_addr, 64'h8000_0200);

    // Redirect to misaligned pc: fault, no memory request
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0202;
    step();
    redirect_valid = 1'b0;
    chk("mis_no_req", 64'(mem_req_valid), 64'd0);
    chk("mis_no_out", 64'(out_valid), 64'd0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("mis_valid", 64'(out_valid), 64'd1);
    chk("mis_fault", 64'(out_fault), 64'd1);
    chk("mis_pc", out_pc, 64'h8000_0202);
    chk("mis_inst", 64'(out_inst), 64'd0);
    chk("mis_hold_no_req", 64'(mem_req_valid), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    step();
    redirect_valid = 1'b0;
    chk("mis_exit_addr", mem_req_addr, 64'h8000_0300);

    // Redirect in REQ together with acceptance -> DROP
    mem_req_ready  = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0400;
    step();
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b0;
    chk("req_redir_drop_no_req", 64'(mem_req_valid), 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEAD_BEEF;
    step();
    mem_resp_valid = 1'b0;
    chk("req_redir_no_out", 64'(out_valid), 64'd0);
    chk("req_redir_req_valid", 64'(mem_req_valid), 64'd1);
    chk("req_redir_addr", mem_req_addr, 64'h8000_0400);

    // Redirect in WAIT together with response -> straight back to REQ
    mem_req_ready = 1'b1;
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEAD_BEEF;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0500;
    step();
    mem_resp_valid = 1'b0;
    redirect_valid = 1'b0;
    chk("wait_resp_redir_no_out", 64'(out_valid), 64'd0);
    chk("wait_resp_redir_req", 64'(mem_req_valid), 64'd1);
    chk("wait_resp_redir_addr", mem_req_addr, 64'h8000_0500);

    // pc+4 wraps at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h0060_0313);
    consume();
    chk("wrap_addr", mem_req_addr, 64'd0);

    // Reset while a fetch is outstanding
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_wait_out_valid", 64'(out_valid), 64'd0);
    chk("rst_wait_no_req", 64'(mem_req_valid), 64'd0);
    chk("rst_wait_out_pc", out_pc, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_wait_req_valid", 64'(mem_req_valid), 64'd1);
    chk("rst_wait_req_addr", mem_req_addr, 64'h8000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_inst_fetch
